// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared DCT pipeline types: coefficient width, block size, read FSM states
package dct_pkg;
    localparam int DATA_W = 12;
    localparam int N      = 8;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;
endpackage

// File: rtl/transpose_buf_if.sv
// rtl/transpose_buf_if.sv - row/column vector stream bundle with valid/ready/last handshake
interface transpose_buf_if #(
    parameter int DATA_W = dct_pkg::DATA_W,
    parameter int N      = dct_pkg::N
);
    logic                       valid;
    logic                       ready;
    logic                       last;
    logic [N-1:0][DATA_W-1:0]   data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/tpose_bank.sv
// rtl/tpose_bank.sv - NxN coefficient register array, row write port, combinational column read port
module tpose_bank #(
    parameter int DATA_W = dct_pkg::DATA_W,
    parameter int N      = dct_pkg::N
) (
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [$clog2(N)-1:0]        row_i,
    input  logic [N-1:0][DATA_W-1:0]    row_data_i,
    input  logic [$clog2(N)-1:0]        col_i,
    output logic [N-1:0][DATA_W-1:0]    col_data_o
);
    logic [N-1:0][DATA_W-1:0] mem_q [N];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[row_i] <= row_data_i;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            col_data_o[k] = mem_q[k][col_i];
        end
    end
endmodule

// File: rtl/transpose_buf.sv
// rtl/transpose_buf.sv - ping-pong 8x8 transpose buffer between row and column DCT; TRANSPOSE_BUF_OVF_EN adds sticky o_ovf
module transpose_buf #(
    parameter int DATA_W = dct_pkg::DATA_W,
    parameter int N      = dct_pkg::N
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data0,
    input  logic signed [DATA_W-1:0] i_data1,
    input  logic signed [DATA_W-1:0] i_data2,
    input  logic signed [DATA_W-1:0] i_data3,
    input  logic signed [DATA_W-1:0] i_data4,
    input  logic signed [DATA_W-1:0] i_data5,
    input  logic signed [DATA_W-1:0] i_data6,
    input  logic signed [DATA_W-1:0] i_data7,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_data0,
    output logic signed [DATA_W-1:0] o_data1,
    output logic signed [DATA_W-1:0] o_data2,
    output logic signed [DATA_W-1:0] o_data3,
    output logic signed [DATA_W-1:0] o_data4,
    output logic signed [DATA_W-1:0] o_data5,
    output logic signed [DATA_W-1:0] o_data6,
    output logic signed [DATA_W-1:0] o_data7,
`ifdef TRANSPOSE_BUF_OVF_EN
    output logic                     o_ovf,
`endif
    output logic                     o_last
);
    import dct_pkg::*;

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef logic [N-1:0][DATA_W-1:0] vec_t;

    vec_t            wr_data;
    vec_t            bank_rd [2];
    logic [CW-1:0]   wr_row_q, wr_row_d;
    logic            wr_bank_q, wr_bank_d;
    logic [1:0]      full_q, full_d;
    rd_state_e       state_q, state_d;
    logic            rd_bank_q, rd_bank_d;
    logic [CW-1:0]   rd_col_q, rd_col_d;
    logic            o_valid_q, o_valid_d;
    logic            o_last_q, o_last_d;
    vec_t            o_data_q, o_data_d;
    logic            wr_en, clr_en, load, ld_bank;
    logic [CW-1:0]   ld_col;

    assign wr_data[0] = i_data0;
    assign wr_data[1] = i_data1;
    assign wr_data[2] = i_data2;
    assign wr_data[3] = i_data3;
    assign wr_data[4] = i_data4;
    assign wr_data[5] = i_data5;
    assign wr_data[6] = i_data6;
    assign wr_data[7] = i_data7;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tpose_bank #(.DATA_W(DATA_W), .N(N)) u_bank (
            .clk_i      (i_clk),
            .we_i       (wr_en && (wr_bank_q == 1'(b))),
            .row_i      (wr_row_q),
            .row_data_i (wr_data),
            .col_i      (ld_col),
            .col_data_o (bank_rd[b])
        );
    end

    // Column address for the next load; kept apart from the FSM so bank read data never feeds back into it
    always_comb begin
        ld_bank = rd_bank_q;
        ld_col  = '0;
        if (state_q == RD_IDLE) begin
            ld_bank = full_q[rd_bank_q] ? rd_bank_q : ~rd_bank_q;
        end else if (rd_col_q != LAST) begin
            ld_col = rd_col_q + 1'b1;
        end else begin
            ld_bank = ~rd_bank_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        clr_en    = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (|full_q) begin
                    load      = 1'b1;
                    o_valid_d = 1'b1;
                    o_last_d  = 1'b0;
                    rd_col_d  = '0;
                    rd_bank_d = ld_bank;
                    state_d   = RD_READ;
                end
            end
            RD_READ: begin
                if (o_valid_q && i_ready) begin
                    if (rd_col_q != LAST) begin
                        load     = 1'b1;
                        rd_col_d = ld_col;
                        o_last_d = (ld_col == LAST);
                    end else begin
                        clr_en    = 1'b1;
                        rd_bank_d = ld_bank;
                        rd_col_d  = '0;
                        o_last_d  = 1'b0;
                        if (full_q[ld_bank]) begin
                            load = 1'b1;
                        end else begin
                            o_valid_d = 1'b0;
                            state_d   = RD_IDLE;
                        end
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    assign o_data_d = load ? bank_rd[ld_bank] : o_data_q;

    // A bank being drained on this edge may already take row 0 of the next block
    always_comb begin
        wr_en     = i_valid && (!full_q[wr_bank_q] || (clr_en && (rd_bank_q == wr_bank_q)));
        wr_row_d  = wr_row_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        if (clr_en) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_en) begin
            if (wr_row_q == LAST) begin
                wr_row_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_row_d = wr_row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_row_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            state_q   <= RD_IDLE;
            rd_bank_q <= 1'b0;
            rd_col_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= '0;
        end else begin
            wr_row_q  <= wr_row_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_data_q  <= o_data_d;
        end
    end

`ifdef TRANSPOSE_BUF_OVF_EN
    logic ovf_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (i_valid && !wr_en) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
`endif

    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_data0 = o_data_q[0];
    assign o_data1 = o_data_q[1];
    assign o_data2 = o_data_q[2];
    assign o_data3 = o_data_q[3];
    assign o_data4 = o_data_q[4];
    assign o_data5 = o_data_q[5];
    assign o_data6 = o_data_q[6];
    assign o_data7 = o_data_q[7];
endmodule

// File: tb/tb_transpose_buf.sv
// tb/tb_transpose_buf.sv - directed scoreboard bench for transpose_buf
module tb_transpose_buf;
    localparam int DW = 12;
    localparam int NN = 8;

    typedef logic [NN-1:0][DW-1:0] vec_t;
    typedef struct packed {
        vec_t data;
        logic last;
    } col_s;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    transpose_buf_if #(.DATA_W(DW), .N(NN)) in_if ();
    transpose_buf_if #(.DATA_W(DW), .N(NN)) out_if ();
`ifdef TRANSPOSE_BUF_OVF_EN
    logic ovf;
`endif

    transpose_buf #(.DATA_W(DW), .N(NN)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_if.valid),
        .i_data0 (in_if.data[0]),
        .i_data1 (in_if.data[1]),
        .i_data2 (in_if.data[2]),
        .i_data3 (in_if.data[3]),
        .i_data4 (in_if.data[4]),
        .i_data5 (in_if.data[5]),
        .i_data6 (in_if.data[6]),
        .i_data7 (in_if.data[7]),
        .i_ready (out_if.ready),
        .o_valid (out_if.valid),
        .o_data0 (out_if.data[0]),
        .o_data1 (out_if.data[1]),
        .o_data2 (out_if.data[2]),
        .o_data3 (out_if.data[3]),
        .o_data4 (out_if.data[4]),
        .o_data5 (out_if.data[5]),
        .o_data6 (out_if.data[6]),
        .o_data7 (out_if.data[7]),
`ifdef TRANSPOSE_BUF_OVF_EN
        .o_ovf   (ovf),
`endif
        .o_last  (out_if.last)
    );

    int   checks  = 0;
    int   errors  = 0;
    int   run_len = 0;
    int   max_run = 0;
    logic toggle_mode = 1'b0;
    logic ready_val   = 1'b1;
    col_s exp_q [$];
    vec_t blk [NN];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic fill_block(input int base);
        for (int r = 0; r < NN; r++)
            for (int c = 0; c < NN; c++)
                blk[r][c] = DW'(base + 8 * r + c);
    endtask

    task automatic push_block();
        col_s e;
        for (int c = 0; c < NN; c++) begin
            for (int k = 0; k < NN; k++) e.data[k] = blk[k][c];
            e.last = (c == NN - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_row(input vec_t r);
        in_if.valid = 1'b1;
        in_if.data  = r;
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic send_block();
        for (int r = 0; r < NN; r++) send_row(blk[r]);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || out_if.valid) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 128'(exp_q.size()), 128'(0));
    endtask

    // Sole driver of i_ready: fixed level or toggling each cycle
    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_if.ready = toggle_mode ? ~out_if.ready : ready_val;
        end
    end

    // Output monitor: every accepted column is popped from the scoreboard
    initial begin
        col_s e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len = 0;
            end else begin
                run_len = out_if.valid ? run_len + 1 : 0;
                if (run_len > max_run) max_run = run_len;
                if (out_if.valid && out_if.ready) begin
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_col got %h exp none", out_if.data);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("col_data", 128'(out_if.data), 128'(e.data));
                        chk("col_last", 128'(out_if.last), 128'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 128'(out_if.valid), 128'(0));
        chk("rst_last",  128'(out_if.last),  128'(0));
        chk("rst_data",  128'(out_if.data),  128'(0));
`ifdef TRANSPOSE_BUF_OVF_EN
        chk("rst_ovf",   128'(ovf),          128'(0));
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single block, element = 8r+c, latency after row 7
        fill_block(0);
        push_block();
        send_block();
        chk("lat_early", 128'(out_if.valid), 128'(0));
        @(posedge clk);
        #1;
        chk("lat_valid", 128'(out_if.valid), 128'(1));
        wait_drain("drain_single");

        // Extreme signed values alternating by column
        for (int r = 0; r < NN; r++)
            for (int c = 0; c < NN; c++)
                blk[r][c] = (c % 2 == 0) ? DW'(-2048) : DW'(2047);
        push_block();
        send_block();
        wait_drain("drain_signed");

        // Three blocks back-to-back must stream out without gaps
        repeat (3) @(posedge clk);
        #1;
        max_run = 0;
        for (int b = 0; b < 3; b++) begin
            fill_block(100 * b + 1000);
            push_block();
            send_block();
        end
        wait_drain("drain_b2b");
        chk("gapless_run", 128'(max_run), 128'(24));
`ifdef TRANSPOSE_BUF_OVF_EN
        chk("b2b_ovf", 128'(ovf), 128'(0));
`endif

        // Stalled consumer: third block finds both banks full and is dropped
        ready_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3 * NN; i++) begin
            if (i % NN == 0) begin
                fill_block(64 * (i / NN) + 2000 - 4096);
                if (i < 2 * NN) push_block();
            end
            if (i == 20) ready_val = 1'b1;
            send_row(blk[i % NN]);
        end
        wait_drain("drain_ovf");
`ifdef TRANSPOSE_BUF_OVF_EN
        chk("ovf_set", 128'(ovf), 128'(1));
`endif

        // Reset with one block pending and a partial block in flight
        ready_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fill_block(300);
        push_block();
        send_block();
        fill_block(500);
        for (int r = 0; r < 5; r++) send_row(blk[r]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("rst_mid_valid", 128'(out_if.valid), 128'(0));
        chk("rst_mid_last",  128'(out_if.last),  128'(0));
`ifdef TRANSPOSE_BUF_OVF_EN
        chk("rst_mid_ovf",   128'(ovf),          128'(0));
`endif
        ready_val = 1'b1;
        fill_block(700);
        push_block();
        send_block();
        wait_drain("drain_after_rst");

        // Consumer toggling ready each cycle
        toggle_mode = 1'b1;
        fill_block(1500);
        push_block();
        send_block();
        wait_drain("drain_toggle");
        toggle_mode = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
